decode_queue: RTL

- Buffered, multi-slot decode stage between instruction fetch and issue in the MIPS32 pipeline.
- Accepts up to FETCH_WIDTH instructions per cycle into a circular queue and presents up to ISSUE_WIDTH in-order decoded slots.
- Per slot it decodes the register write enable, the destination register and a branch/jump flag.
- It enforces the branch/delay-slot pairing rule and supports a single-cycle flush.

---
 rtl/decode_queue_if.sv | 31 +++
 rtl/decode_queue.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/decode_queue_if.sv
// Fetch-to-issue bus of the decode queue: fetch bundle in, decoded issue slots out.
interface decode_queue_if #(
   parameter int unsigned FETCH_WIDTH = 2,
   parameter int unsigned ISSUE_WIDTH = 2
);
   localparam int unsigned IC_W = $clog2(FETCH_WIDTH + 1);
   localparam int unsigned OA_W = $clog2(ISSUE_WIDTH + 1);

   logic                       in_valid;
   logic [IC_W-1:0]            in_count;
   logic [32*FETCH_WIDTH-1:0]  in_instr;
   logic [32*FETCH_WIDTH-1:0]  in_pc;
   logic                       in_ready;
   logic [ISSUE_WIDTH-1:0]     out_valid;
   logic [32*ISSUE_WIDTH-1:0]  out_instr;
   logic [32*ISSUE_WIDTH-1:0]  out_pc;
   logic [ISSUE_WIDTH-1:0]     out_reg_write;
   logic [5*ISSUE_WIDTH-1:0]   out_write_reg;
   logic [ISSUE_WIDTH-1:0]     out_is_branch;
   logic [OA_W-1:0]            out_accept;

   modport master (
      output in_valid, in_count, in_instr, in_pc, out_accept,
      input  in_ready, out_valid, out_instr, out_pc, out_reg_write, out_write_reg, out_is_branch
   );

   modport slave (
      input  in_valid, in_count, in_instr, in_pc, out_accept,
      output in_ready, out_valid, out_instr, out_pc, out_reg_write, out_write_reg, out_is_branch
   );
endinterface

// File: rtl/decode_queue.sv
// Circular decode queue between fetch and issue: pre-decodes MIPS32 words on write and
// presents an in-order prefix of slots that never splits a branch from its delay slot.
module decode_queue #(
   parameter int unsigned FETCH_WIDTH = 2,
   parameter int unsigned ISSUE_WIDTH = 2,
   parameter int unsigned DEPTH       = 8
) (
   input logic          clk,
   input logic          reset,
   input logic          flush,
   decode_queue_if.slave bus
);
   localparam int unsigned PTR_W = $clog2(DEPTH);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned IC_W  = $clog2(FETCH_WIDTH + 1);

   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc;
      logic        reg_write;
      logic [4:0]  write_reg;
      logic        is_branch;
   } entry_t;

   entry_t           mem [DEPTH];
   logic [PTR_W-1:0] head;
   logic [PTR_W-1:0] tail;
   logic [CNT_W-1:0] count;
   logic             ready;
   logic             push;
   logic [CNT_W-1:0] push_n;
   logic [CNT_W-1:0] pop_n;
   logic             wr_en   [FETCH_WIDTH];
   logic [PTR_W-1:0] wr_idx  [FETCH_WIDTH];
   entry_t           wr_data [FETCH_WIDTH];
   entry_t           slot    [ISSUE_WIDTH];

   // Pre-decode of register write, destination and control-transfer flag.
   function automatic entry_t decode(input logic [31:0] instr, input logic [31:0] pc);
      entry_t     e;
      logic [5:0] op;
      logic [5:0] funct;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] rd;
      op    = instr[31:26];
      rs    = instr[25:21];
      rt    = instr[20:16];
      rd    = instr[15:11];
      funct = instr[5:0];
      e.instr     = instr;
      e.pc        = pc;
      e.reg_write = 1'b0;
      e.write_reg = 5'd0;
      e.is_branch = 1'b0;
      case (op)
         6'h00: begin
            case (funct)
               6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h10, 6'h12,
               6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27,
               6'h2a, 6'h2b: begin
                  e.reg_write = 1'b1;
                  e.write_reg = rd;
               end
               6'h08: e.is_branch = 1'b1;
               6'h09: begin
                  e.is_branch = 1'b1;
                  e.reg_write = 1'b1;
                  e.write_reg = rd;
               end
               default: ;
            endcase
         end
         6'h01: begin
            case (rt)
               5'h00, 5'h01: e.is_branch = 1'b1;
               5'h10, 5'h11: begin
                  e.is_branch = 1'b1;
                  e.reg_write = 1'b1;
                  e.write_reg = 5'd31;
               end
               default: ;
            endcase
         end
         6'h02, 6'h04, 6'h05, 6'h06, 6'h07: e.is_branch = 1'b1;
         6'h03: begin
            e.is_branch = 1'b1;
            e.reg_write = 1'b1;
            e.write_reg = 5'd31;
         end
         6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0d, 6'h0e, 6'h0f,
         6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26: begin
            e.reg_write = 1'b1;
            e.write_reg = rt;
         end
         6'h10: begin
            if (rs == 5'h00) begin
               e.reg_write = 1'b1;
               e.write_reg = rt;
            end
         end
         6'h1c: begin
            if (funct == 6'h02) begin
               e.reg_write = 1'b1;
               e.write_reg = rd;
            end
         end
         default: ;
      endcase
      if (instr == 32'h0) e.reg_write = 1'b0;
      return e;
   endfunction

   // Occupancy-only ready keeps fetch free of any combinational path from issue.
   assign ready        = (CNT_W'(DEPTH) - count) >= CNT_W'(FETCH_WIDTH);
   assign bus.in_ready = ready;
   assign push         = bus.in_valid && ready && !flush;
   assign push_n       = push ? CNT_W'(bus.in_count) : '0;
   assign pop_n        = CNT_W'(bus.out_accept);

   always_comb begin
      for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
         wr_en[i]   = push && (IC_W'(i) < bus.in_count);
         wr_idx[i]  = tail + PTR_W'(i);
         wr_data[i] = decode(bus.in_instr[32*i +: 32], bus.in_pc[32*i +: 32]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset || flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(bus.out_accept);
         tail  <= tail + PTR_W'(push_n);
         count <= count + push_n - pop_n;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned j = 0; j < DEPTH; j++) mem[j] <= '0;
      end else begin
         for (int unsigned i = 0; i < FETCH_WIDTH; i++) begin
            if (wr_en[i]) mem[wr_idx[i]] <= wr_data[i];
         end
      end
   end

   always_comb begin
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) slot[i] = mem[head + PTR_W'(i)];
   end

   // Valid prefix; a branch without its delay slot in view ends the prefix at itself.
   always_comb begin
      logic blocked;
      logic v;
      bus.out_valid     = '0;
      bus.out_instr     = '0;
      bus.out_pc        = '0;
      bus.out_reg_write = '0;
      bus.out_write_reg = '0;
      bus.out_is_branch = '0;
      blocked = 1'b0;
      v       = 1'b0;
      for (int unsigned i = 0; i < ISSUE_WIDTH; i++) begin
         bus.out_instr[32*i +: 32]  = slot[i].instr;
         bus.out_pc[32*i +: 32]     = slot[i].pc;
         bus.out_reg_write[i]       = slot[i].reg_write;
         bus.out_write_reg[5*i +: 5] = slot[i].write_reg;
         bus.out_is_branch[i]       = slot[i].is_branch;
         v = !blocked && (CNT_W'(i) < count);
         if (ISSUE_WIDTH > 1 && v && slot[i].is_branch &&
             !((i + 1 < ISSUE_WIDTH) && (CNT_W'(i + 1) < count))) begin
            v = 1'b0;
         end
         blocked = blocked || !v;
         bus.out_valid[i] = v;
      end
   end
endmodule
